// File: rtl/mem_byte_bridge_pkg.sv
// Shared definitions for the CPU-word to byte-RAM bridge: FSM encodings and width helpers.
package mem_byte_bridge_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_WR    = 3'd1;
   localparam logic [STATE_W-1:0] ST_RD    = 3'd2;
   localparam logic [STATE_W-1:0] ST_RLAST = 3'd3;
   localparam logic [STATE_W-1:0] ST_ACK   = 3'd4;

   // Byte counter width; a single-byte word still needs one counter bit.
   function automatic int cnt_width(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/mem_byte_bridge_byte_shift_reg.sv
// Word register that loads a full word, then shifts right one byte per step:
// the low byte feeds the RAM on writes, the RAM byte enters at the top on reads.
module byte_shift_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_dat_i,
   input  logic              shift_i,
   input  logic [7:0]        byte_i,
   output logic [7:0]        byte_o,
   output logic [DATA_W-1:0] shift_dat_o
);

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] shift_d;

   if (DATA_W == 8) begin : g_byte
      assign shift_d = byte_i;
   end else begin : g_word
      assign shift_d = {byte_i, data_q[DATA_W-1:8]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= load_dat_i;
      end else if (shift_i) begin
         data_q <= shift_d;
      end
   end

   assign byte_o      = data_q[7:0];
   assign shift_dat_o = shift_d;

endmodule

// File: rtl/mem_byte_bridge.sv
// Serialises CPU word reads/writes into little-endian byte accesses on a synchronous byte RAM.
// Write acks NB+1 cycles after acceptance, read acks NB+2; writes win when both requests are up.
module mem_byte_bridge
   import mem_byte_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_re,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] read_addr,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic [DATA_W-1:0] c_rdata,
   output logic              m_rack,
   output logic              m_wack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam int NB    = DATA_W / 8;
   localparam int CNT_W = cnt_width(NB);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic               is_wr_q, is_wr_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;

   logic               sr_load;
   logic               sr_shift;
   logic [7:0]         sr_byte_in;
   logic [7:0]         sr_byte_out;
   logic [DATA_W-1:0]  sr_shift_dat;
   logic               last_byte;

   assign last_byte = (cnt_q == CNT_W'(NB - 1));

   // Writes shift zeros in behind the outgoing bytes; reads shift the RAM byte in at the top.
   assign sr_byte_in = is_wr_q ? 8'h00 : mem_rdata;

   byte_shift_reg #(
      .DATA_W (DATA_W)
   ) u_shift (
      .clk         (clk),
      .rst         (rst),
      .load_i      (sr_load),
      .load_dat_i  (c_wdata),
      .shift_i     (sr_shift),
      .byte_i      (sr_byte_in),
      .byte_o      (sr_byte_out),
      .shift_dat_o (sr_shift_dat)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      base_d   = base_q;
      is_wr_d  = is_wr_q;
      rdata_d  = rdata_q;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (c_we) begin
               state_d = ST_WR;
               cnt_d   = '0;
               base_d  = write_addr;
               is_wr_d = 1'b1;
               sr_load = 1'b1;
            end else if (c_re) begin
               state_d = ST_RD;
               cnt_d   = '0;
               base_d  = read_addr;
               is_wr_d = 1'b0;
               sr_load = 1'b1;
            end
         end
         ST_WR: begin
            sr_shift = 1'b1;
            if (last_byte) begin
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RD: begin
            // RAM data lags the strobe by one cycle, so byte 0 has nothing to capture yet.
            sr_shift = (cnt_q != '0);
            if (last_byte) begin
               state_d = ST_RLAST;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RLAST: begin
            sr_shift = 1'b1;
            rdata_d  = sr_shift_dat;
            state_d  = ST_ACK;
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         is_wr_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         is_wr_q <= is_wr_d;
         rdata_q <= rdata_d;
      end
   end

   assign mem_en    = (state_q == ST_WR) || (state_q == ST_RD);
   assign mem_we    = (state_q == ST_WR);
   assign mem_addr  = base_q + ADDR_W'(cnt_q);
   assign mem_wdata = sr_byte_out;
   assign m_wack    = (state_q == ST_ACK) && is_wr_q;
   assign m_rack    = (state_q == ST_ACK) && !is_wr_q;
   assign c_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Directed bench for mem_byte_bridge: vector table of word transactions against a byte RAM model,
// plus hand-written sequences for simultaneous requests and reset in the middle of a read.
module tb_mem_byte_bridge;

   localparam int NB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c_re = 1'b0;
   logic        c_we = 1'b0;
   logic [31:0] read_addr = '0;
   logic [31:0] write_addr = '0;
   logic [31:0] c_wdata = '0;
   logic [31:0] c_rdata;
   logic        m_rack, m_wack;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;

   mem_byte_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .c_re       (c_re),
      .c_we       (c_we),
      .read_addr  (read_addr),
      .write_addr (write_addr),
      .c_wdata    (c_wdata),
      .c_rdata    (c_rdata),
      .m_rack     (m_rack),
      .m_wack     (m_wack),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [logic [31:0]];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] = mem_wdata;
         else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 8'h00;
      end
   end

   int n_cmp = 0;
   int n_err = 0;
   int both_cnt = 0;

   always @(negedge clk) if (m_wack && m_rack) both_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          chg_cycle;
      logic [31:0] chg_addr;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t        vecs [7];
   logic [31:0] aseq [8];
   logic [7:0]  dseq [8];
   logic        weseq [8];
   int          nen;

   task automatic run_txn(input vec_t v, output int lat, output logic [31:0] rd);
      nen = 0;
      lat = 0;
      rd  = '0;
      @(negedge clk);
      if (v.we) begin
         c_we = 1'b1; write_addr = v.addr; c_wdata = v.wdata;
      end else begin
         c_re = 1'b1; read_addr = v.addr;
      end
      @(posedge clk);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (mem_en) begin
            if (nen < 8) begin
               aseq[nen] = mem_addr; dseq[nen] = mem_wdata; weseq[nen] = mem_we;
            end
            nen++;
         end
         if (m_wack || m_rack) begin
            lat = n;
            rd  = c_rdata;
            chk("ack_kind", {31'b0, m_wack}, {31'b0, v.we});
            break;
         end
         if (n == v.chg_cycle) read_addr = v.chg_addr;
      end
      @(posedge clk);
      #1;
      c_we = 1'b0;
      c_re = 1'b0;
      @(negedge clk);
      chk("ack_one_cycle", {30'b0, m_wack, m_rack}, 32'd0);
   endtask

   initial begin
      int          lat, wn, rn;
      logic [31:0] rd;
      int          ack_cnt;

      ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
      ram[32'h300] = 8'hAA; ram[32'h301] = 8'hBB; ram[32'h302] = 8'hCC; ram[32'h303] = 8'hDD;

      //           we  addr          wdata         chg chg_addr      exp_rdata     lat
      vecs[0] = '{1'b0, 32'h0000_0200, 32'h0,        0, 32'h0,        32'h4433_2211, 6};
      vecs[1] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0,        32'h4433_2211, 5};
      vecs[2] = '{1'b0, 32'h0000_0100, 32'h0,        0, 32'h0,        32'hDEAD_BEEF, 6};
      vecs[3] = '{1'b1, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 0, 32'h0,        32'hDEAD_BEEF, 5};
      vecs[4] = '{1'b0, 32'hFFFF_FFFE, 32'h0,        0, 32'h0,        32'hA1B2_C3D4, 6};
      vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,        0, 32'h0,        32'h0000_A1B2, 6};
      vecs[6] = '{1'b0, 32'h0000_0200, 32'h0,        2, 32'h0000_0300, 32'h4433_2211, 6};

      #12;
      chk("rst_mem_en",    {31'b0, mem_en}, 32'd0);
      chk("rst_mem_we",    {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr",  mem_addr, 32'd0);
      chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
      chk("rst_acks",      {30'b0, m_wack, m_rack}, 32'd0);
      chk("rst_c_rdata",   c_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i], lat, rd);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_c_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d_nbytes", i), nen, NB);
         for (int k = 0; k < NB; k++) begin
            chk($sformatf("v%0d_addr%0d", i, k), aseq[k], vecs[i].addr + 32'(k));
            chk($sformatf("v%0d_we%0d", i, k), {31'b0, weseq[k]}, {31'b0, vecs[i].we});
            if (vecs[i].we)
               chk($sformatf("v%0d_wbyte%0d", i, k), {24'b0, dseq[k]}, (vecs[i].wdata >> (8 * k)) & 32'hFF);
         end
         if (i == 3) begin
            chk("wrap_addr0", aseq[0], 32'hFFFF_FFFE);
            chk("wrap_addr1", aseq[1], 32'hFFFF_FFFF);
            chk("wrap_addr2", aseq[2], 32'h0000_0000);
            chk("wrap_addr3", aseq[3], 32'h0000_0001);
         end
      end

      // Both requests together: the write goes first, the read follows once IDLE is back.
      @(negedge clk);
      c_we = 1'b1; c_re = 1'b1;
      write_addr = 32'h300; c_wdata = 32'h9988_7766; read_addr = 32'h300;
      @(posedge clk);
      wn = 0; rn = 0; rd = '0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (m_rack) begin
            rn = n; rd = c_rdata;
            break;
         end
         if (m_wack) begin
            wn = n;
            @(posedge clk);
            #1 c_we = 1'b0;
         end
      end
      @(posedge clk);
      #1 c_re = 1'b0;
      chk("simul_wack_cycle", wn, 5);
      chk("simul_rack_cycle", rn, 12);
      chk("simul_rdata", rd, 32'h9988_7766);

      // Reset while the read is on byte 2.
      @(negedge clk);
      c_re = 1'b1; read_addr = 32'h200;
      @(posedge clk);
      repeat (3) @(negedge clk);
      chk("mid_rd_mem_en", {31'b0, mem_en}, 32'd1);
      chk("mid_rd_addr", mem_addr, 32'h202);
      #1 rst = 1'b1;
      #1;
      chk("rst_abort_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_abort_c_rdata", c_rdata, 32'd0);
      c_re = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      ack_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (m_rack || m_wack) ack_cnt++;
      end
      chk("rst_no_ack", ack_cnt, 0);
      run_txn(vecs[0], lat, rd);
      chk("post_rst_latency", lat, 6);
      chk("post_rst_rdata", rd, 32'h4433_2211);

      chk("never_both_acks", both_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_byte_bridge.md
MEM_BYTE_BRIDGE -- requirements
Module: mem_byte_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, CPU word width; legal values are multiples of 8, giving NB = DATA_W/8 bytes per word.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst, input, 1; reset rst, asynchronous, active-high; clock clk.
REQ-005 SHALL have port c_re, input, 1, CPU read request (level, held until m_rack).
REQ-006 SHALL have port c_we, input, 1, CPU write request (level, held until m_wack).
REQ-007 SHALL have port read_addr, input, ADDR_W, read word byte address.
REQ-008 SHALL have port write_addr, input, ADDR_W, write word byte address.
REQ-009 SHALL have port c_wdata, input, DATA_W, write word from CPU.
REQ-010 SHALL have port c_rdata, output, DATA_W, read word to CPU.
REQ-011 SHALL have port m_rack, output, 1, one-cycle read-complete pulse.
REQ-012 SHALL have port m_wack, output, 1, one-cycle write-complete pulse.
REQ-013 SHALL have port mem_en, output, 1, byte access strobe to synchronous byte RAM.
REQ-014 SHALL have port mem_we, output, 1, byte write enable (valid only with mem_en).
REQ-015 SHALL have port mem_addr, output, ADDR_W, byte address.
REQ-016 SHALL have port mem_wdata, output, 8, byte write data.
REQ-017 SHALL have port mem_rdata, input, 8, byte read data, valid the cycle after mem_en && !mem_we.

Function
REQ-018 SHALL implement FSM states IDLE, WR, RD, RLAST, ACK.
REQ-019 In IDLE, SHALL latch address and c_wdata at the clock edge where c_we or c_re is high; c_we wins if both are high (c_re stays pending).
REQ-020 SHALL ignore address and data input changes after acceptance until the next IDLE.
REQ-021 In WR, SHALL issue NB consecutive cycles of mem_en=1, mem_we=1, mem_addr = base+k, mem_wdata = byte k (little-endian: bits 8k+7:8k), for k = 0..NB-1, then go to ACK.
REQ-022 In RD, SHALL issue NB consecutive cycles of mem_en=1, mem_we=0, mem_addr = base+k, then go to RLAST.
REQ-023 SHALL capture mem_rdata into byte k-1 of the assembly register in the cycle after byte k-1 is issued; RLAST captures byte NB-1 and goes to ACK.
REQ-024 ACK SHALL last one cycle, pulsing exactly one of m_wack/m_rack, then return to IDLE.
REQ-025 Latency from accepting edge to ack cycle: write NB+1 cycles, read NB+2 cycles (NB=4: 5 and 6).
REQ-026 SHALL update c_rdata only at read completion, and it SHALL be valid from the m_rack cycle until the next read completes.
REQ-027 Address increments SHALL wrap modulo 2^ADDR_W.
REQ-028 mem_en SHALL be 0 in IDLE, RLAST and ACK; no back-to-back transaction SHALL begin before IDLE is re-entered.
REQ-029 The requester deasserts its request on the edge after the ack cycle; the bridge SHALL NOT re-accept in ACK.
REQ-030 Byte counter SHALL be $clog2(NB) bits (minimum 1) and SHALL reset to 0 on every acceptance.

Reset
REQ-031 On rst, SHALL go to IDLE immediately and asynchronously, aborting any transaction without an ack.
REQ-032 Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, m_rack=0, m_wack=0, c_rdata=0, counter=0.

Structure
REQ-033 FSM state encodings and NB-derived width macros SHALL reside in the shared def.v define file.
REQ-034 The read assembly/write disassembly SHALL form one natural sub-module, byte_shift_reg (DATA_W-wide load/shift-in-byte/shift-out-byte register).

Verification
REQ-035 Write: c_we=1, write_addr=0x100, c_wdata=0xDEADBEEF -> bytes EF,BE,AD,DE to 0x100..0x103 in cycles 1-4, m_wack high in cycle 5 only.
REQ-036 Read: RAM 0x200..0x203 = 11,22,33,44, c_re=1, read_addr=0x200 -> m_rack in cycle 6, c_rdata=0x44332211, held until the next read.
REQ-037 Simultaneous: c_re=c_we=1 in IDLE -> write completes (m_wack) first, then read is accepted and m_rack follows; never both acks in one cycle.
REQ-038 Wrap: write_addr=0xFFFFFFFE -> mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-039 Reset mid-read (asserted in RD byte 2) -> mem_en=0 immediately, no m_rack, c_rdata=0; a new read after reset completes normally.
REQ-040 Address change after acceptance (read_addr 0x200->0x300 in cycle 2) -> all bytes still from 0x200..0x203.
